// File: rtl/rob_pkg.sv
// Shared widths and entry layout for the reorder buffer and its lookup ports.
package rob_pkg;

    localparam int unsigned ROB_REG_ADDRESS_SIZE = 5;
    localparam int unsigned ROB_REG_SIZE         = 32;
    localparam int unsigned ROB_ID_SIZE          = 2;
    localparam int unsigned ROB_DEPTH            = 1 << ROB_ID_SIZE;
    localparam int unsigned ROB_CNT_SIZE         = ROB_ID_SIZE + 1;

    typedef logic [ROB_ID_SIZE-1:0]  rob_id_t;
    typedef logic [ROB_CNT_SIZE-1:0] rob_cnt_t;

    // One in-flight op: lifecycle flags, destination and captured result.
    typedef struct packed {
        logic                            valid;
        logic                            done;
        logic                            w;
        logic [ROB_REG_ADDRESS_SIZE-1:0] dest;
        logic [ROB_REG_SIZE-1:0]         value;
    } rob_entry_t;

endpackage

// File: rtl/rob_lookup.sv
// Dependency lookup: youngest in-flight writer of addr, with same-cycle completion forwarding.
module rob_lookup
    import rob_pkg::*;
#(
    parameter int unsigned REG_ADDRESS_SIZE = ROB_REG_ADDRESS_SIZE,
    parameter int unsigned REG_SIZE         = ROB_REG_SIZE,
    parameter int unsigned ID_SIZE          = ROB_ID_SIZE
) (
    input  rob_entry_t                  entries [1 << ID_SIZE],
    input  logic [ID_SIZE-1:0]          head,
    input  logic [REG_ADDRESS_SIZE-1:0] addr,
    input  logic                        alu_done,
    input  logic [ID_SIZE-1:0]          alu_id,
    input  logic [REG_SIZE-1:0]         alu_value,
    input  logic                        mul_done,
    input  logic [ID_SIZE-1:0]          mul_id,
    input  logic [REG_SIZE-1:0]         mul_value,
    output logic                        dependency,
    output logic                        resolved,
    output logic [REG_SIZE-1:0]         value
);

    localparam int unsigned DEPTH = 1 << ID_SIZE;

    logic               found;
    logic [ID_SIZE-1:0] sel;
    logic [ID_SIZE-1:0] idx;
    logic               alu_hit;
    logic               mul_hit;

    // Walk oldest->youngest from head; the last hit is the youngest writer.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + ID_SIZE'(i);
            if (entries[idx].valid && entries[idx].w &&
                (entries[idx].dest == addr) && (addr != '0)) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Forward a completion landing this cycle; ALU takes priority on an ID clash.
    always_comb begin
        alu_hit    = alu_done && (alu_id == sel);
        mul_hit    = mul_done && (mul_id == sel);
        dependency = found;
        resolved   = found && (entries[sel].done || alu_hit || mul_hit);
        value      = '0;
        if (found) begin
            if (alu_hit)
                value = alu_value;
            else if (mul_hit)
                value = mul_value;
            else
                value = entries[sel].value;
        end
    end

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder buffer: tracks issued ALU/MUL ops, gathers completions, retires in order to the bank.
module rob_commit_ctrl
    import rob_pkg::*;
#(
    parameter int unsigned REG_ADDRESS_SIZE = ROB_REG_ADDRESS_SIZE,
    parameter int unsigned REG_SIZE         = ROB_REG_SIZE,
    parameter int unsigned ID_SIZE          = ROB_ID_SIZE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        RC_alloc,
    input  logic [ID_SIZE-1:0]          RC_alloc_id,
    input  logic [REG_ADDRESS_SIZE-1:0] RC_alloc_dest,
    input  logic                        RC_alloc_w,
    input  logic                        RC_alu_done,
    input  logic [ID_SIZE-1:0]          RC_alu_id,
    input  logic [REG_SIZE-1:0]         RC_alu_value,
    input  logic                        RC_mul_done,
    input  logic [ID_SIZE-1:0]          RC_mul_id,
    input  logic [REG_SIZE-1:0]         RC_mul_value,
    input  logic [REG_ADDRESS_SIZE-1:0] RC_dAddr1,
    output logic                        RC_dependency1,
    output logic                        RC_resolved1,
    output logic [REG_SIZE-1:0]         RC_dValue1,
    input  logic [REG_ADDRESS_SIZE-1:0] RC_dAddr2,
    output logic                        RC_dependency2,
    output logic                        RC_resolved2,
    output logic [REG_SIZE-1:0]         RC_dValue2,
    output logic [REG_ADDRESS_SIZE-1:0] RC_Wat,
    output logic [REG_SIZE-1:0]         RC_Wvalue,
    output logic                        RC_We,
    output logic                        RC_rob_stall,
    output logic                        RC_empty,
    input  logic                        RC_flush
);

    localparam int unsigned DEPTH = 1 << ID_SIZE;
    localparam int unsigned CNT_W = ID_SIZE + 1;

    rob_entry_t         entries [DEPTH];
    logic [ID_SIZE-1:0] head;
    logic [CNT_W-1:0]   count;

    logic full;
    logic commit_go;
    logic alloc_go;
    logic alu_go;
    logic mul_go;

    // Status flags and per-cycle qualified events; flush suppresses every update.
    always_comb begin
        full         = (count == CNT_W'(DEPTH));
        RC_rob_stall = full;
        RC_empty     = (count == '0);
        commit_go    = entries[head].valid && entries[head].done && !RC_flush;
        alloc_go     = RC_alloc && !full && !RC_flush;
        alu_go       = RC_alu_done && !RC_flush && entries[RC_alu_id].valid;
        mul_go       = RC_mul_done && !RC_flush && entries[RC_mul_id].valid &&
                       !(RC_alu_done && (RC_alu_id == RC_mul_id));
    end

    // Entry array: completions, then commit retire, then allocation (newest op wins a slot).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                entries[i] <= '0;
        end else if (RC_flush) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                entries[i].valid <= 1'b0;
        end else begin
            if (alu_go) begin
                entries[RC_alu_id].done  <= 1'b1;
                entries[RC_alu_id].value <= RC_alu_value;
            end
            if (mul_go) begin
                entries[RC_mul_id].done  <= 1'b1;
                entries[RC_mul_id].value <= RC_mul_value;
            end
            if (commit_go)
                entries[head].valid <= 1'b0;
            if (alloc_go) begin
                entries[RC_alloc_id].valid <= 1'b1;
                entries[RC_alloc_id].done  <= 1'b0;
                entries[RC_alloc_id].w     <= RC_alloc_w;
                entries[RC_alloc_id].dest  <= RC_alloc_dest;
            end
        end
    end

    // Head pointer and occupancy; flush realigns head with the issue tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            count <= '0;
        end else if (RC_flush) begin
            head  <= RC_alloc_id;
            count <= '0;
        end else begin
            if (commit_go)
                head <= head + 1'b1;
            count <= count + CNT_W'(alloc_go) - CNT_W'(commit_go);
        end
    end

    // Registered commit port; Wat is forced to 0 whenever no write is presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RC_We     <= 1'b0;
            RC_Wat    <= '0;
            RC_Wvalue <= '0;
        end else if (commit_go) begin
            RC_We     <= entries[head].w;
            RC_Wat    <= entries[head].w ? entries[head].dest : '0;
            RC_Wvalue <= entries[head].value;
        end else begin
            RC_We  <= 1'b0;
            RC_Wat <= '0;
        end
    end

    rob_lookup #(
        .REG_ADDRESS_SIZE (REG_ADDRESS_SIZE),
        .REG_SIZE         (REG_SIZE),
        .ID_SIZE          (ID_SIZE)
    ) u_lookup1 (
        .entries    (entries),
        .head       (head),
        .addr       (RC_dAddr1),
        .alu_done   (RC_alu_done),
        .alu_id     (RC_alu_id),
        .alu_value  (RC_alu_value),
        .mul_done   (RC_mul_done),
        .mul_id     (RC_mul_id),
        .mul_value  (RC_mul_value),
        .dependency (RC_dependency1),
        .resolved   (RC_resolved1),
        .value      (RC_dValue1)
    );

    rob_lookup #(
        .REG_ADDRESS_SIZE (REG_ADDRESS_SIZE),
        .REG_SIZE         (REG_SIZE),
        .ID_SIZE          (ID_SIZE)
    ) u_lookup2 (
        .entries    (entries),
        .head       (head),
        .addr       (RC_dAddr2),
        .alu_done   (RC_alu_done),
        .alu_id     (RC_alu_id),
        .alu_value  (RC_alu_value),
        .mul_done   (RC_mul_done),
        .mul_id     (RC_mul_id),
        .mul_value  (RC_mul_value),
        .dependency (RC_dependency2),
        .resolved   (RC_resolved2),
        .value      (RC_dValue2)
    );

endmodule
